// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative on-the-fly AES-128 inverse key schedule.
// Loads the cipher key, expands it forward to the round-10 key (one step per
// cycle), then walks it backwards one round per accepted valid/ready transfer,
// presenting round keys 10, 9, ..., 0 to the decryption round stage.
// Build option: define INV_KEY_EQUIV_EN to emit InvMixColumns(round key) for
// rounds 9..1 (equivalent inverse cipher); rounds 10 and 0 pass unchanged.

`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

module inv_key_schedule #(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_load_i,
  input  logic [`TEXT_WIDTH-1:0] key_i,
  input  logic                   rk_ready_i,
  output logic                   rk_valid_o,
  output logic [127:0]           rk_o,
  output logic [3:0]             rk_round_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_REV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Undoes xtime: 0x36 -> 0x1b, 0x1b -> 0x80, 0x02 -> 0x01.
  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return b[0] ? (((b ^ 8'h1b) >> 1) | 8'h80) : (b >> 1);
  endfunction

`ifdef INV_KEY_EQUIV_EN
  // One column of InvMixColumns; byte 0 of the column is the top byte.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      x2[i] = xtime(s[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ s[i];
      mb[i] = x8[i] ^ x2[i] ^ s[i];
      md[i] = x8[i] ^ x4[i] ^ s[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
    return {inv_mix_column(k[127:96]), inv_mix_column(k[95:64]),
            inv_mix_column(k[63:32]),  inv_mix_column(k[31:0])};
  endfunction
`endif

  logic [1:0]   state;
  logic [127:0] kreg;
  logic [7:0]   rcon;
  logic [3:0]   cnt;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  inv_w3, sub_in, sub_out, head;
  logic [31:0]  f1, f2, f3;
  logic [127:0] fwd_key, inv_key, rk_next;

  assign {w0, w1, w2, w3} = kreg;

  // Both directions need SubWord(RotWord(x)) ^ rcon folded into w0; only the
  // word fed to the S-boxes differs (old w3 forwards, recovered w3 backwards).
  assign inv_w3  = w3 ^ w2;
  assign sub_in  = (state == S_FWD) ? w3 : inv_w3;
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]});
  assign head    = w0 ^ sub_out ^ {rcon, 24'h0};

  assign f1      = w1 ^ head;
  assign f2      = w2 ^ f1;
  assign f3      = w3 ^ f2;
  assign fwd_key = {head, f1, f2, f3};
  assign inv_key = {head, w1 ^ w0, w2 ^ w1, inv_w3};

  // Key to present after an inverse step; inner rounds optionally get InvMixColumns.
  always_comb begin
    // NOTE: assign a default before any conditional so no path leaves rk_next unassigned (no latch).
    rk_next = inv_key;
`ifdef INV_KEY_EQUIV_EN
    if (rk_round_o != 4'd1) rk_next = inv_mix_columns(inv_key);
`endif
  end

  // Control FSM, key register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state      <= S_IDLE;
      kreg       <= '0;
      rcon       <= '0;
      cnt        <= '0;
      rk_valid_o <= 1'b0;
      rk_o       <= '0;
      rk_round_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_load_i) begin
            kreg   <= key_i;
            rcon   <= 8'h01;
            cnt    <= '0;
            busy_o <= 1'b1;
            state  <= S_FWD;
          end
        end
        S_FWD: begin
          kreg <= fwd_key;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'(NR - 1)) begin
            // rcon keeps the last-used constant: the first inverse step needs it.
            state      <= S_REV;
            rk_valid_o <= 1'b1;
            rk_o       <= fwd_key;
            rk_round_o <= 4'(NR);
          end else begin
            rcon <= xtime(rcon);
          end
        end
        S_REV: begin
          if (rk_valid_o && rk_ready_i) begin
            if (rk_round_o == 4'd0) begin
              rk_valid_o <= 1'b0;
              done_o     <= 1'b1;
              state      <= S_DONE;
            end else begin
              kreg       <= inv_key;
              rcon       <= inv_xtime(rcon);
              rk_round_o <= rk_round_o - 4'd1;
              rk_o       <= rk_next;
            end
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: scoreboard bench for inv_key_schedule.
// The reference model builds the S-box from GF(2^8) inversion plus the affine
// map and expands keys with the textbook 44-word recurrence; expected round
// keys are queued at load time and a monitor pops them on every transfer.
// Honours INV_KEY_EQUIV_EN the same way as the design.

module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load_i;
  logic [127:0] key_i;
  logic         rk_ready_i;
  logic         rk_valid_o;
  logic [127:0] rk_o;
  logic [3:0]   rk_round_o;
  logic         busy_o;
  logic         done_o;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  inv_key_schedule #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load_i (key_load_i),
    .key_i      (key_i),
    .rk_ready_i (rk_ready_i),
    .rk_valid_o (rk_valid_o),
    .rk_o       (rk_o),
    .rk_round_o (rk_round_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   round;
  } exp_t;

  exp_t         sb [$];
  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sbox_t  [0:255];
  logic [127:0] model_rk [0:10];
  logic [127:0] exp_out  [0:10];
  logic [127:0] got_key  [0:10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] imc_model(input logic [127:0] v);
    logic [127:0] r;
    logic [7:0]   s [0:3];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) s[j] = v[127-32*c-8*j -: 8];
      for (int j = 0; j < 4; j++)
        r[127-32*c-8*j -: 8] = gmul(8'h0e, s[j]) ^ gmul(8'h0b, s[(j+1)%4]) ^
                               gmul(8'h0d, s[(j+2)%4]) ^ gmul(8'h09, s[(j+3)%4]);
    end
    return r;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_out[r]  = model_rk[r];
`ifdef INV_KEY_EQUIV_EN
      if (r != 0 && r != 10) exp_out[r] = imc_model(model_rk[r]);
`endif
    end
  endtask

  task automatic push_expected(input logic [127:0] k);
    exp_t e;
    build_model(k);
    for (int r = 10; r >= 0; r--) begin
      e.key   = exp_out[r];
      e.round = 4'(r);
      sb.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rk_valid_o === 1'b1 && rk_ready_i === 1'b1) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rk_round", rk_round_o, e.round);
          check("rk_key", rk_o, e.key);
          if (rk_round_o <= 4'd10) got_key[rk_round_o] = rk_o;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [127:0] k);
    @(posedge clk); #1;
    key_load_i = 1'b1;
    key_i      = k;
    push_expected(k);
    @(posedge clk); #1;
    key_load_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (rk_valid_o !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_done(input bit rnd, output int n);
    n = 0;
    while (done_o !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (rnd) rk_ready_i = 1'($urandom_range(0, 1));
    end
    rk_ready_i = 1'b1;
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n;
    n = 0;
    while (!(rk_valid_o === 1'b1 && rk_round_o == r) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("reach_round_%0d", r), {rk_valid_o, rk_round_o}, {1'b1, r});
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int           n;
    bit           saw;
    logic [127:0] ka, kb;

    build_sbox();
    for (int r = 0; r <= 10; r++) got_key[r] = '0;
    rst_n = 1'b0; key_load_i = 1'b0; key_i = '0; rk_ready_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", rk_valid_o, 0);
    check("reset_rk", rk_o, 0);
    check("reset_round", rk_round_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    rst_n = 1'b1;

    // FIPS-197 key, consumer always ready.
    rk_ready_i = 1'b1;
    do_load(FIPS_KEY);
    check("busy_after_load", busy_o, 1);
    wait_valid(n);
    check("first_valid_latency", n, 10);
    check("first_round", rk_round_o, 10);
    check("fips_rk10", rk_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done(0, n);
    check("done_latency", n, 11);
    check("busy_in_done", busy_o, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done_o, 0);
    check("busy_fall", busy_o, 0);
    check("fips_drained", sb.size(), 0);
`ifdef INV_KEY_EQUIV_EN
    check("fips_rk9", got_key[9], imc_model(128'hac7766f319fadc2128d12941575c006e));
    check("fips_rk1", got_key[1], imc_model(128'ha0fafe1788542cb123a339392a6c7605));
`else
    check("fips_rk9", got_key[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_rk1", got_key[1], 128'ha0fafe1788542cb123a339392a6c7605);
`endif
    check("fips_rk0", got_key[0], FIPS_KEY);

    // Random keys with a randomly stalling consumer.
    for (int i = 0; i < 4; i++) begin
      do_load(rand_key());
      wait_done(1, n);
      check("rand_done_seen", done_o, 1);
      check("rand_drained", sb.size(), 0);
    end

    // Backpressure at round 7 for 5 cycles.
    do_load(rand_key());
    wait_round(4'd7);
    rk_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", rk_valid_o, 1);
      check("bp_round", rk_round_o, 7);
      check("bp_key", rk_o, exp_out[7]);
    end
    rk_ready_i = 1'b1;
    wait_done(0, n);
    check("bp_done_seen", done_o, 1);
    check("bp_drained", sb.size(), 0);

    // Load strobes while busy (once in FWD, once in REV) are ignored.
    ka = rand_key();
    kb = ~ka;
    do_load(ka);
    repeat (3) @(posedge clk);
    #1;
    key_load_i = 1'b1; key_i = kb;
    check("busy_during_fwd", busy_o, 1);
    @(posedge clk); #1;
    key_load_i = 1'b0;
    wait_round(4'd5);
    key_load_i = 1'b1; key_i = kb;
    @(posedge clk); #1;
    key_load_i = 1'b0;
    wait_done(0, n);
    check("lwb_done_seen", done_o, 1);
    saw = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (rk_valid_o !== 1'b0 || busy_o !== 1'b0) saw = 1'b1;
    end
    check("lwb_no_restart", saw, 0);
    check("lwb_drained", sb.size(), 0);

    // Asynchronous reset in the middle of the reverse walk.
    do_load(FIPS_KEY);
    wait_round(4'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", rk_valid_o, 0);
    check("midrst_rk", rk_o, 0);
    check("midrst_round", rk_round_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_done", done_o, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_load('0);
    wait_valid(n);
    check("zero_latency", n, 10);
    check("zero_rk10", rk_o, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    wait_done(0, n);
    check("zero_drained", sb.size(), 0);

    // Back-to-back: load held from the DONE cycle into the first IDLE cycle.
    do_load(rand_key());
    wait_done(0, n);
    check("b2b_first_done", n, 21);
    kb = rand_key();
    key_load_i = 1'b1; key_i = kb;
    push_expected(kb);
    @(posedge clk); #1;
    check("load_in_done_ignored", busy_o, 0);
    @(posedge clk); #1;
    key_load_i = 1'b0;
    check("b2b_busy", busy_o, 1);
    wait_valid(n);
    check("b2b_latency", n, 10);
    wait_done(0, n);
    check("b2b_done_latency", n, 11);
    check("b2b_drained", sb.size(), 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
